// File: rtl/cla_pkg.sv
// Shared types and constants for the L2 cache-line to 64-bit burst adaptor.
// Optional build macro used by the adaptor: CLA_PERF_CNT_EN (line counters).
package cla_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int OFFSET_W = 5;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int CNT_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cla_state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cla_beat_counter.sv
// Modulo-BEATS beat index with synchronous clear/enable and a last-beat flag.
module cla_beat_counter
  import cla_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [BEAT_W-1:0] beat_o,
  output logic              last_o
);

  logic [BEAT_W-1:0] beat_q, beat_d;

  assign last_o = (beat_q == BEAT_W'(BEATS - 1));
  assign beat_o = beat_q;

  always_comb begin
    // NOTE: next-state gets its default first so no path leaves it unassigned (no latch).
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (en) begin
      beat_d = last_o ? '0 : beat_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) beat_q <= '0;
    else     beat_q <= beat_d;
  end

endmodule

// File: rtl/l2_cacheline_adaptor.sv
// Converts 256-bit L2 line reads/writes into 4-beat 64-bit memory bursts.
// Define CLA_PERF_CNT_EN to add saturating read/write line counters.
module l2_cacheline_adaptor
  import cla_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CLA_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   rd_line_cnt_o,
  output logic [CNT_W-1:0]   wr_line_cnt_o
`endif
);

  cla_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BEAT_W-1:0] beat;
  logic              beat_last;
  logic              beat_en;

  // Offset bits are dropped by line alignment.
  logic unused_offset_bits;
  assign unused_offset_bits = ^address_i[OFFSET_W-1:0];

  assign beat_en = resp_i && ((state_q == RD) || (state_q == WR));

  cla_beat_counter u_beat_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .en     (beat_en),
    .beat_o (beat),
    .last_o (beat_last)
  );

`ifdef CLA_PERF_CNT_EN
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  assign rd_line_cnt_o = rd_cnt_q;
  assign wr_line_cnt_o = wr_cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
`ifdef CLA_PERF_CNT_EN
    is_wr_d  = is_wr_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Write wins when L2 raises both requests together.
        if (write_i) begin
          wdata_d = line_i;
          addr_d  = line_align(address_i);
          state_d = WR;
`ifdef CLA_PERF_CNT_EN
          is_wr_d = 1'b1;
`endif
        end else if (read_i) begin
          addr_d  = line_align(address_i);
          state_d = RD;
`ifdef CLA_PERF_CNT_EN
          is_wr_d = 1'b0;
`endif
        end
      end

      RD: begin
        read_o = 1'b1;
        if (resp_i) begin
          for (int i = 0; i < BEATS; i++) begin
            if (beat == BEAT_W'(i)) line_d[i*BURST_W +: BURST_W] = burst_i;
          end
          if (beat_last) state_d = DONE;
        end
      end

      WR: begin
        write_o = 1'b1;
        for (int i = 0; i < BEATS; i++) begin
          if (beat == BEAT_W'(i)) burst_o = wdata_q[i*BURST_W +: BURST_W];
        end
        if (resp_i && beat_last) state_d = DONE;
      end

      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
`ifdef CLA_PERF_CNT_EN
        if (is_wr_q) begin
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
        end else begin
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  assign line_o    = line_q;
  assign address_o = addr_q;

  // Data registers are cleared too: reset must drive every output to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
`ifdef CLA_PERF_CNT_EN
      is_wr_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
`ifdef CLA_PERF_CNT_EN
      is_wr_q  <= is_wr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Self-checking bench: directed cases plus randomized line traffic against a line-level model.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
`ifdef CLA_PERF_CNT_EN
  logic [31:0]  rd_line_cnt_o;
  logic [31:0]  wr_line_cnt_o;
`endif

  l2_cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef CLA_PERF_CNT_EN
    ,
    .rd_line_cnt_o (rd_line_cnt_o),
    .wr_line_cnt_o (wr_line_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what L2 should see on line_o, and completed line counts.
  logic [255:0] model_line = '0;
  int           model_rd   = 0;
  int           model_wr   = 0;
  int           resp_pat[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic logic next_resp(input bit gaps);
    if (resp_pat.size() > 0) return resp_pat.pop_front() != 0;
    if (!gaps) return 1'b1;
    return $urandom_range(0, 99) >= 30;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] mem_line, input bit gaps);
    logic [31:0] exp_addr;
    int n;
    int cyc;
    logic r;
    exp_addr = addr & 32'hFFFF_FFE0;
    n = 0;
    cyc = 0;
    read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
    @(negedge clk);
    while (n < 4) begin
      check("rd_read_o", read_o, 1'b1);
      check("rd_write_o", write_o, 1'b0);
      check("rd_resp_early", resp_o, 1'b0);
      check("rd_address_o", address_o, exp_addr);
      if (n == 0) check("rd_line_hold", line_o, model_line);
      address_i = $urandom;
      r = next_resp(gaps);
      resp_i  = r;
      burst_i = r ? mem_line[64*n +: 64] : {$urandom, $urandom};
      if (r) n++;
      @(negedge clk);
      cyc++;
      if (cyc > 64) begin
        check("rd_timeout", 1'b0, 1'b1);
        break;
      end
    end
    resp_i = 1'b0;
    model_line = mem_line;
    model_rd++;
    check("rd_resp_pulse", resp_o, 1'b1);
    check("rd_read_o_done", read_o, 1'b0);
    check("rd_line_o", line_o, model_line);
    check("rd_address_done", address_o, exp_addr);
    read_i = 1'b0;
    @(negedge clk);
    check("rd_resp_single", resp_o, 1'b0);
    check("rd_line_stable", line_o, model_line);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [255:0] wline, input bit both,
                           input bit gaps);
    logic [31:0] exp_addr;
    int n;
    int cyc;
    logic r;
    exp_addr = addr & 32'hFFFF_FFE0;
    n = 0;
    cyc = 0;
    write_i = 1'b1; read_i = both; line_i = wline; address_i = addr; resp_i = 1'b0;
    @(negedge clk);
    while (n < 4) begin
      check("wr_write_o", write_o, 1'b1);
      check("wr_read_o", read_o, 1'b0);
      check("wr_resp_early", resp_o, 1'b0);
      check("wr_address_o", address_o, exp_addr);
      check("wr_burst_o", burst_o, wline[64*n +: 64]);
      line_i = rand_line();
      address_i = $urandom;
      burst_i = {$urandom, $urandom};
      r = next_resp(gaps);
      resp_i = r;
      if (r) n++;
      @(negedge clk);
      cyc++;
      if (cyc > 64) begin
        check("wr_timeout", 1'b0, 1'b1);
        break;
      end
    end
    resp_i = 1'b0;
    model_wr++;
    check("wr_resp_pulse", resp_o, 1'b1);
    check("wr_write_o_done", write_o, 1'b0);
    check("wr_line_o_kept", line_o, model_line);
    write_i = 1'b0; read_i = 1'b0;
    @(negedge clk);
    check("wr_resp_single", resp_o, 1'b0);
  endtask

  initial begin
    logic [255:0] l;
    logic [63:0]  b1, b2, b3, b4;
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b1;
    line_i = '1; address_i = '1; burst_i = '1;
    repeat (2) @(negedge clk);
    check("rst_resp_o", resp_o, 1'b0);
    check("rst_read_o", read_o, 1'b0);
    check("rst_write_o", write_o, 1'b0);
    check("rst_address_o", address_o, 32'h0);
    check("rst_burst_o", burst_o, 64'h0);
    check("rst_line_o", line_o, 256'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ignores_resp", resp_o, 1'b0);
    resp_i = 1'b0;

    // Zero-wait read of the example line.
    b1 = {16{4'h1}}; b2 = {16{4'h2}}; b3 = {16{4'h3}}; b4 = {16{4'h4}};
    run_read(32'h0000_1234, {b4, b3, b2, b1}, 1'b0);
    check("rd_addr_1220", address_o, 32'h0000_1220);

    // Write with wait states: burst_o should read A,B,B,B,C,D,D.
    b1 = {16{4'hA}}; b2 = {16{4'hB}}; b3 = {16{4'hC}}; b4 = {16{4'hD}};
    resp_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_write(32'h0000_8ABC, {b4, b3, b2, b1}, 1'b0, 1'b0);
    check("addr_held_idle", address_o, 32'h0000_8AA0);

    // Simultaneous read/write request takes the write path.
    run_write($urandom, rand_line(), 1'b1, 1'b1);

    // Back-to-back read then write; line_o keeps the read data through the write.
    run_read($urandom, rand_line(), 1'b1);
    run_write($urandom, rand_line(), 1'b0, 1'b1);

    // Reset after the first read beat abandons the transaction.
    read_i = 1'b1; address_i = 32'hDEAD_BEEF;
    @(negedge clk);
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    resp_i = 1'b0; rst = 1'b1; read_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_read_o", read_o, 1'b0);
      check("midrst_resp_o", resp_o, 1'b0);
      check("midrst_line_o", line_o, 256'h0);
      check("midrst_address_o", address_o, 32'h0);
    end
    rst = 1'b0;
    model_line = '0;
    model_rd = 0;
    model_wr = 0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_no_resp", resp_o, 1'b0);
    end
    run_read($urandom, rand_line(), 1'b0);

    // Randomized traffic mix.
    for (int t = 0; t < 24; t++) begin
      l = rand_line();
      case ($urandom_range(0, 2))
        0:       run_read($urandom, l, 1'b1);
        1:       run_write($urandom, l, 1'b0, 1'b1);
        default: run_write($urandom, l, 1'b1, 1'b1);
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

`ifdef CLA_PERF_CNT_EN
    check("rd_line_cnt", rd_line_cnt_o, 32'(model_rd));
    check("wr_line_cnt", wr_line_cnt_o, 32'(model_wr));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
